// File: rtl/method_ctrl_pkg.sv
// rtl/method_ctrl_pkg.sv - shared state encoding for the method run controller
package method_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_REQ     = 3'd2,
        S_RUN     = 3'd3,
        S_DONE    = 3'd4,
        S_TIMEOUT = 3'd5
    } state_e;

    // States in which a new go request is accepted.
    function automatic logic accepts_go(input state_e s);
        return (s == S_IDLE) || (s == S_DONE) || (s == S_TIMEOUT);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter with synchronous clear that holds at all-ones instead of wrapping
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/method_run_controller.sv
// rtl/method_run_controller.sv - launches one core method via req/busy, counts run cycles,
// reports sticky done/timeout status
import method_ctrl_pkg::*;

module method_run_controller #(
    parameter int unsigned STARTUP_CYCLES = 4,
    parameter int unsigned ACK_WINDOW     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    output logic               dut_req,
    input  logic               dut_busy,
    input  logic               dut_finish,
    output logic               done,
    output logic               timeout,
    output logic [CNT_W-1:0]   cycles,
    output logic [STATE_W-1:0] state_o
);

    localparam logic [63:0] STARTUP_LIM = 64'(STARTUP_CYCLES);
    localparam logic [63:0] ACK_LIM     = 64'(ACK_WINDOW);
    localparam logic [63:0] RUN_LIM     = 64'(TIMEOUT_CYCLES);

    state_e state_q, state_d;
    logic   dut_req_q, dut_req_d;
    logic   done_q, done_d;
    logic   timeout_q, timeout_d;
    logic   busy_prev_q;

    logic             tmr_clr, tmr_en;
    logic             cyc_clr, cyc_en;
    logic [CNT_W-1:0] tmr_cnt;
    logic [63:0]      tmr_ext;
    logic             busy_fall;

    // One timer serves ARM (startup wait), REQ (ack window) and RUN (run limit);
    // it is cleared on every entry into those states.
    sat_counter #(.W(CNT_W)) u_tmr (
        .clk   (clk),
        .reset (reset),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .cnt   (tmr_cnt)
    );

    sat_counter #(.W(CNT_W)) u_cyc (
        .clk   (clk),
        .reset (reset),
        .clr   (cyc_clr),
        .en    (cyc_en),
        .cnt   (cycles)
    );

    assign tmr_ext   = 64'(tmr_cnt);
    assign busy_fall = busy_prev_q & ~dut_busy;

    always_comb begin
        state_d   = state_q;
        dut_req_d = 1'b0;
        done_d    = done_q;
        timeout_d = timeout_q;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;
        cyc_clr   = 1'b0;
        cyc_en    = 1'b0;

        if (accepts_go(state_q)) begin
            if (go) begin
                state_d   = S_ARM;
                tmr_clr   = 1'b1;
                cyc_clr   = 1'b1;
                done_d    = 1'b0;
                timeout_d = 1'b0;
            end
        end else begin
            case (state_q)
                S_ARM: begin
                    if (tmr_ext >= STARTUP_LIM) begin
                        state_d = S_REQ;
                        tmr_clr = 1'b1;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                S_REQ: begin
                    // A busy already high on entry is taken as the ack before req ever rises.
                    if (dut_busy) begin
                        state_d = S_RUN;
                        tmr_clr = 1'b1;
                    end else if (tmr_ext >= ACK_LIM) begin
                        state_d   = S_TIMEOUT;
                        timeout_d = 1'b1;
                    end else begin
                        tmr_en    = 1'b1;
                        dut_req_d = 1'b1;
                    end
                end
                S_RUN: begin
                    cyc_en = 1'b1;
                    tmr_en = 1'b1;
                    // Completion is tested first so it beats a coincident run limit.
                    if (busy_fall || dut_finish) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if ((tmr_ext + 64'd1) >= RUN_LIM) begin
                        state_d   = S_TIMEOUT;
                        timeout_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            dut_req_q   <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            busy_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dut_req_q   <= dut_req_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            busy_prev_q <= dut_busy;
        end
    end

    assign dut_req = dut_req_q;
    assign done    = done_q;
    assign timeout = timeout_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_method_run_controller.sv
// tb/tb_method_run_controller.sv - table-driven scoreboard bench for method_run_controller
module tb_method_run_controller;

    localparam int NEVER = 0;
    localparam int STUCK = 100000;

    typedef struct {
        int   busy_len;
        int   fin_at;
        logic exp_done;
        logic exp_to;
        int   exp_cyc;
        int   exp_req;
    } vec_t;

    typedef struct {
        int   id;
        logic done;
        logic to;
        int   cyc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        go, busy, finish;
    logic        req, done, timeout;
    logic [31:0] cycles;
    logic [2:0]  state;

    logic        go_b, busy_b, finish_b;
    logic        req_b, done_b, timeout_b;
    logic [3:0]  cycles_b;
    logic [2:0]  state_b;

    int   n_tests;
    int   n_fail;
    exp_t sb[$];
    vec_t vecs[9];

    method_run_controller #(
        .STARTUP_CYCLES (4),
        .ACK_WINDOW     (16),
        .TIMEOUT_CYCLES (50),
        .CNT_W          (32)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .dut_req    (req),
        .dut_busy   (busy),
        .dut_finish (finish),
        .done       (done),
        .timeout    (timeout),
        .cycles     (cycles),
        .state_o    (state)
    );

    method_run_controller #(
        .CNT_W (4)
    ) u_dut4 (
        .clk        (clk),
        .reset      (reset),
        .go         (go_b),
        .dut_req    (req_b),
        .dut_busy   (busy_b),
        .dut_finish (finish_b),
        .done       (done_b),
        .timeout    (timeout_b),
        .cycles     (cycles_b),
        .state_o    (state_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int g;
        g = 0;
        while (state != s && g < budget) begin
            @(negedge clk);
            g++;
        end
        chk(name, (state == s), 1);
    endtask

    // Drives one go pulse on u_dut, models a core that raises busy one cycle after it sees req,
    // holds it busy_len cycles and optionally pulses finish, then scores the result.
    task automatic run_vec(input vec_t v, input int id, input bit hold_go);
        exp_t e;
        exp_t g;
        int   t, lat, req_cnt, guard;
        bit   got_req, bad_req;
        e.id = id; e.done = v.exp_done; e.to = v.exp_to; e.cyc = v.exp_cyc;
        sb.push_back(e);
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        if (!hold_go) go = 1'b0;
        t = -1; lat = 0; req_cnt = 0; guard = 0; got_req = 0; bad_req = 0;
        while (!(state == 3'd4 || state == 3'd5) && guard < 3000) begin
            if (req) begin
                req_cnt++;
                if (!got_req) begin
                    got_req = 1;
                    t = 0;
                end
                if (state != 3'd2) bad_req = 1;
            end
            if (!got_req) lat++;
            if (t >= 0) begin
                busy   = (v.busy_len > 0) && (t >= 1) && (t <= v.busy_len);
                finish = (v.fin_at > 0) && (t == 1 + v.fin_at);
                t++;
            end
            @(negedge clk);
            guard++;
        end
        busy   = 1'b0;
        finish = 1'b0;
        chk($sformatf("v%0d_completes", id), (guard < 3000), 1);
        g = sb.pop_front();
        chk($sformatf("v%0d_done", g.id), done, g.done);
        chk($sformatf("v%0d_timeout", g.id), timeout, g.to);
        chk($sformatf("v%0d_cycles", g.id), cycles, g.cyc);
        chk($sformatf("v%0d_state", g.id), state, g.done ? 4 : 5);
        chk($sformatf("v%0d_req_cycles", id), req_cnt, v.exp_req);
        chk($sformatf("v%0d_req_latency", id), lat, 6);
        chk($sformatf("v%0d_req_low_at_end", id), req, 0);
        chk($sformatf("v%0d_req_only_in_REQ", id), bad_req, 0);
    endtask

    initial begin
        exp_t e;
        exp_t g;
        int   guard;
        int   arm_cnt;
        bit   req_seen;

        n_tests = 0;
        n_fail  = 0;
        vecs[0] = '{20,    0,  1'b1, 1'b0, 20, 2};
        vecs[1] = '{NEVER, 0,  1'b0, 1'b1, 0,  16};
        vecs[2] = '{STUCK, 0,  1'b0, 1'b1, 50, 2};
        vecs[3] = '{20,    7,  1'b1, 1'b0, 7,  2};
        vecs[4] = '{STUCK, 50, 1'b1, 1'b0, 50, 2};
        vecs[5] = '{1,     0,  1'b1, 1'b0, 1,  2};
        vecs[6] = '{50,    0,  1'b1, 1'b0, 50, 2};
        vecs[7] = '{51,    0,  1'b0, 1'b1, 50, 2};
        vecs[8] = '{49,    0,  1'b1, 1'b0, 49, 2};

        reset = 1'b0;
        go = 1'b0; busy = 1'b0; finish = 1'b0;
        go_b = 1'b0; busy_b = 1'b0; finish_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_req", req, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_cycles", cycles, 0);
        chk("rst_b_state", state_b, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_without_go", state, 0);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], i, 1'b0);
        end

        // Async reset while req is high: req must drop without a clock edge.
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        guard = 0;
        while (!req && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("areq_seen", req, 1);
        #2 reset = 1'b0;
        #1 chk("areq_async_drop", req, 0);
        chk("areq_async_state", state, 0);
        @(negedge clk);
        reset = 1'b1;

        // Reset during RUN cycle 5, then a clean full run.
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        guard = 0;
        while (!req && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        busy = 1'b1;
        wait_state(3'd3, 10, "rrun_enters_run");
        repeat (4) @(negedge clk);
        chk("rrun_cycles_before", cycles, 4);
        #2 reset = 1'b0;
        #1 chk("rrun_state", state, 0);
        chk("rrun_cycles", cycles, 0);
        chk("rrun_done", done, 0);
        chk("rrun_req", req, 0);
        @(negedge clk);
        busy = 1'b0;
        reset = 1'b1;
        run_vec(vecs[0], 100, 1'b0);

        // go held high: ignored mid-run, restarts immediately from DONE.
        run_vec(vecs[0], 101, 1'b1);
        @(negedge clk);
        chk("hold_restart_state", state, 1);
        chk("hold_restart_done_clr", done, 0);
        chk("hold_restart_cycles_clr", cycles, 0);
        go = 1'b0;
        wait_state(3'd5, 100, "hold_second_run_acktimeout");
        chk("hold_second_timeout", timeout, 1);

        // busy already high during ARM: no early advance, immediate ack on REQ entry.
        e.id = 102; e.done = 1'b1; e.to = 1'b0; e.cyc = 1;
        sb.push_back(e);
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        busy = 1'b1;
        arm_cnt = 0;
        req_seen = 0;
        while (state == 3'd1 && arm_cnt < 50) begin
            arm_cnt++;
            @(negedge clk);
        end
        chk("arm_busy_arm_cycles", arm_cnt, 5);
        chk("arm_busy_in_req", state, 2);
        if (req) req_seen = 1;
        @(negedge clk);
        chk("arm_busy_to_run", state, 3);
        if (req) req_seen = 1;
        chk("arm_busy_no_req", req_seen, 0);
        busy = 1'b0;
        wait_state(3'd4, 10, "arm_busy_completes");
        g = sb.pop_front();
        chk($sformatf("v%0d_done", g.id), done, g.done);
        chk($sformatf("v%0d_timeout", g.id), timeout, g.to);
        chk($sformatf("v%0d_cycles", g.id), cycles, g.cyc);

        // Narrow counter: a 30-cycle run saturates cycles at 15.
        e.id = 103; e.done = 1'b1; e.to = 1'b0; e.cyc = 15;
        sb.push_back(e);
        @(negedge clk);
        go_b = 1'b1;
        @(negedge clk);
        go_b = 1'b0;
        guard = 0;
        while (!req_b && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("sat_req_seen", req_b, 1);
        @(negedge clk);
        busy_b = 1'b1;
        repeat (30) @(negedge clk);
        busy_b = 1'b0;
        guard = 0;
        while (state_b != 3'd4 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("sat_completes", state_b, 4);
        g = sb.pop_front();
        chk($sformatf("v%0d_done", g.id), done_b, g.done);
        chk($sformatf("v%0d_timeout", g.id), timeout_b, g.to);
        chk($sformatf("v%0d_cycles", g.id), cycles_b, g.cyc);

        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
